// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller.
// Holds the funct3 compare encodings, the controller state enum
// and the link offset that produces pc+4.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam int LINK_OFFSET = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_REDIRECT
    } state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of the issue, result, redirect and statistics signals of the
// branch resolution controller.
//   master : decode/fetch/perf-monitor side (drives in_*, redirect_ready, clr_stats)
//   slave  : the controller itself
interface branch_resolve_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic [2:0]       in_br_op;
    logic             in_is_jal;
    logic             in_is_jalr;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_link;
    logic             flush;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             misalign_exc;
    logic             illegal_op;
    logic             clr_stats;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_br_op,
               in_is_jal, in_is_jalr, in_pred_taken, in_pred_target,
               redirect_ready, clr_stats,
        input  in_ready, res_valid, res_taken, res_link, flush,
               redirect_valid, redirect_pc, misalign_exc, illegal_op,
               br_cnt, mispred_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_br_op,
               in_is_jal, in_is_jalr, in_pred_taken, in_pred_target,
               redirect_ready, clr_stats,
        output in_ready, res_valid, res_taken, res_link, flush,
               redirect_valid, redirect_pc, misalign_exc, illegal_op,
               br_cnt, mispred_cnt
    );

endinterface

// File: rtl/branch_resolve_ctrl_comp.sv
// Branch comparator: evaluates the funct3 condition on two operands.
//   rs1, rs2 : operands
//   br_op    : funct3 compare code
//   taken    : condition holds (0 for unsupported codes)
//   illegal  : br_op is not a defined compare code
module branch_comp
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      br_op,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_op)
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution controller.
// Accepts one branch/jump at a time, resolves it in a single RESOLVE cycle,
// flags misaligned targets and mispredicts, and on a mispredict holds a
// redirect request to fetch until it is accepted. Keeps saturating counters
// of resolved branches and mispredicts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : issue (in_*), result (res_*, flush, misalign_exc, illegal_op),
//                redirect handshake and statistics signals
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_ctrl_if.slave  bus
);

    state_e           state;
    state_e           state_next;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  imm_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  pred_target_q;
    logic [2:0]       br_op_q;
    logic             is_jal_q;
    logic             is_jalr_q;
    logic             pred_taken_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic             cmp_taken;
    logic             cmp_illegal;
    logic             is_jump;
    logic             taken;
    logic             misalign;
    logic             mispred;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    logic [XLEN-1:0]  next_pc;

    branch_comp #(.XLEN(XLEN)) u_branch_comp (
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .br_op   (br_op_q),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // A jal+jalr combination falls out as jalr because is_jalr alone picks the target.
    assign is_jump  = is_jal_q | is_jalr_q;
    assign taken    = is_jump | cmp_taken;
    assign jalr_sum = rs1_q + imm_q;
    assign target   = is_jalr_q ? (jalr_sum & ~XLEN'(1)) : (pc_q + imm_q);
    assign link     = pc_q + XLEN'(LINK_OFFSET);
    assign next_pc  = taken ? target : link;
    assign misalign = taken & target[1];
    assign mispred  = (taken != pred_taken_q) | (taken & (target != pred_target_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pred_target_q <= '0;
            br_op_q       <= '0;
            is_jal_q      <= 1'b0;
            is_jalr_q     <= 1'b0;
            pred_taken_q  <= 1'b0;
        end else if (state == ST_IDLE && bus.in_valid) begin
            pc_q          <= bus.in_pc;
            imm_q         <= bus.in_imm;
            rs1_q         <= bus.in_rs1_data;
            rs2_q         <= bus.in_rs2_data;
            pred_target_q <= bus.in_pred_target;
            br_op_q       <= bus.in_br_op;
            is_jal_q      <= bus.in_is_jal;
            is_jalr_q     <= bus.in_is_jalr;
            pred_taken_q  <= bus.in_pred_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                // A misaligned target traps; the trap unit owns the redirect.
                if (misalign)     state_next = ST_IDLE;
                else if (mispred) state_next = ST_REDIRECT;
                else              state_next = ST_IDLE;
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.res_valid      = 1'b0;
        bus.res_taken      = 1'b0;
        bus.res_link       = '0;
        bus.flush          = 1'b0;
        bus.misalign_exc   = 1'b0;
        bus.illegal_op     = 1'b0;
        bus.redirect_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = rst_n;
            end
            ST_RESOLVE: begin
                bus.res_valid    = 1'b1;
                bus.res_taken    = taken;
                bus.res_link     = link;
                bus.flush        = misalign | mispred;
                bus.misalign_exc = misalign;
                bus.illegal_op   = ~is_jump & cmp_illegal;
            end
            ST_REDIRECT: begin
                bus.redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_q <= '0;
        end else if (state == ST_RESOLVE && mispred && !misalign) begin
            redirect_pc_q <= next_pc;
        end
    end

    // Clear has priority over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.clr_stats) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (state == ST_RESOLVE) begin
            if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispred && !misalign && mispred_cnt_q != '1)
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign bus.redirect_pc = redirect_pc_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed cases followed by
// randomized branches, compared against a behavioural reference model.
module tb_branch_resolve_ctrl;

    localparam int TB_CNT_W = 2;
    localparam int MAXCNT   = (1 << TB_CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   brCount;
    int   mispredCount;

    logic [31:0] rPc, rImm, rRs1, rRs2, rTgt;
    logic [2:0]  rOp;
    logic        rJal, rJalr, rPt, rClr;
    int          rWait;

    branch_resolve_ctrl_if #(.XLEN(32), .CNT_W(TB_CNT_W)) bus ();

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXCNT) ? MAXCNT : v;
    endfunction

    function automatic logic [31:0] modelTarget(input logic [31:0] pc, imm, rs1, input logic jalr);
        logic [31:0] sum;
        sum = rs1 + imm;
        return jalr ? {sum[31:1], 1'b0} : pc + imm;
    endfunction

    // Resolution rules written straight from the architectural definition.
    function automatic void modelResolve(
        input  logic [31:0] pc, imm, rs1, rs2,
        input  logic [2:0]  op,
        input  logic        jal, jalr, pt,
        input  logic [31:0] ptgt,
        output logic        taken,
        output logic [31:0] npc,
        output logic        mis,
        output logic        misal,
        output logic        ill
    );
        logic [31:0] tgt;
        logic        slt;
        slt   = (rs1 ^ 32'h8000_0000) < (rs2 ^ 32'h8000_0000);
        ill   = 1'b0;
        taken = 1'b0;
        case (op)
            3'd0:    taken = (rs1 == rs2);
            3'd1:    taken = (rs1 != rs2);
            3'd4:    taken = slt;
            3'd5:    taken = !slt;
            3'd6:    taken = (rs1 < rs2);
            3'd7:    taken = !(rs1 < rs2);
            default: ill = 1'b1;
        endcase
        if (jal || jalr) begin
            taken = 1'b1;
            ill   = 1'b0;
        end
        tgt   = modelTarget(pc, imm, rs1, jalr);
        npc   = taken ? tgt : pc + 32'd4;
        misal = taken && tgt[1];
        mis   = (taken != pt) || (taken && tgt != ptgt);
    endfunction

    // Called from a negedge context; reset is asserted mid-cycle and released on the next negedge.
    task automatic doReset();
        #2;
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.redirect_ready = 1'b0;
        bus.clr_stats      = 1'b0;
        brCount            = 0;
        mispredCount       = 0;
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_res_taken", bus.res_taken, 0);
        checkOutput("rst_res_link", bus.res_link, 0);
        checkOutput("rst_flush", bus.flush, 0);
        checkOutput("rst_redirect_valid", bus.redirect_valid, 0);
        checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
        checkOutput("rst_misalign", bus.misalign_exc, 0);
        checkOutput("rst_illegal", bus.illegal_op, 0);
        checkOutput("rst_br_cnt", 32'(bus.br_cnt), 0);
        checkOutput("rst_mispred_cnt", 32'(bus.mispred_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1);
        checkOutput("post_rst_redirect_valid", bus.redirect_valid, 0);
    endtask

    task automatic applyStimulus(
        input logic [31:0] pc, imm, rs1, rs2,
        input logic [2:0]  op,
        input logic        jal, jalr, pt,
        input logic [31:0] ptgt,
        input logic        clr,
        input int          waitCycles,
        input int          rstAt
    );
        logic        expTaken, expMis, expMisal, expIll, expRedir;
        logic [31:0] expNpc;
        modelResolve(pc, imm, rs1, rs2, op, jal, jalr, pt, ptgt,
                     expTaken, expNpc, expMis, expMisal, expIll);
        expRedir = expMis && !expMisal;

        @(negedge clk);
        checkOutput("in_ready_idle", bus.in_ready, 1);
        bus.in_valid       = 1'b1;
        bus.in_pc          = pc;
        bus.in_imm         = imm;
        bus.in_rs1_data    = rs1;
        bus.in_rs2_data    = rs2;
        bus.in_br_op       = op;
        bus.in_is_jal      = jal;
        bus.in_is_jalr     = jalr;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;

        @(negedge clk);
        // Scramble the inputs so the result must come from the captured copy.
        bus.in_valid       = 1'b0;
        bus.in_pc          = $urandom;
        bus.in_rs1_data    = $urandom;
        bus.in_rs2_data    = $urandom;
        bus.in_pred_taken  = ~pt;
        bus.clr_stats      = clr;
        checkOutput("res_valid", bus.res_valid, 1);
        checkOutput("res_taken", bus.res_taken, expTaken);
        checkOutput("res_link", bus.res_link, pc + 32'd4);
        checkOutput("flush", bus.flush, expMis | expMisal);
        checkOutput("misalign_exc", bus.misalign_exc, expMisal);
        checkOutput("illegal_op", bus.illegal_op, expIll);
        checkOutput("in_ready_resolve", bus.in_ready, 0);
        checkOutput("redirect_valid_resolve", bus.redirect_valid, 0);
        if (clr) begin
            brCount      = 0;
            mispredCount = 0;
        end else begin
            brCount = sat(brCount + 1);
            if (expRedir) mispredCount = sat(mispredCount + 1);
        end

        @(negedge clk);
        bus.clr_stats = 1'b0;
        checkOutput("br_cnt", 32'(bus.br_cnt), 32'(brCount));
        checkOutput("mispred_cnt", 32'(bus.mispred_cnt), 32'(mispredCount));
        checkOutput("res_valid_after", bus.res_valid, 0);
        if (expRedir) begin
            for (int i = 0; i < waitCycles; i++) begin
                checkOutput("redir_wait_valid", bus.redirect_valid, 1);
                checkOutput("redir_wait_pc", bus.redirect_pc, expNpc);
                checkOutput("redir_wait_in_ready", bus.in_ready, 0);
                if (i == rstAt) begin
                    doReset();
                    return;
                end
                @(negedge clk);
            end
            checkOutput("redirect_valid", bus.redirect_valid, 1);
            checkOutput("redirect_pc", bus.redirect_pc, expNpc);
            bus.redirect_ready = 1'b1;
            @(negedge clk);
            bus.redirect_ready = 1'b0;
            checkOutput("redirect_drop", bus.redirect_valid, 0);
            checkOutput("in_ready_after_redir", bus.in_ready, 1);
        end else begin
            checkOutput("no_redirect", bus.redirect_valid, 0);
            checkOutput("in_ready_t2", bus.in_ready, 1);
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        brCount            = 0;
        mispredCount       = 0;
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_imm         = '0;
        bus.in_rs1_data    = '0;
        bus.in_rs2_data    = '0;
        bus.in_br_op       = '0;
        bus.in_is_jal      = 1'b0;
        bus.in_is_jalr     = 1'b0;
        bus.in_pred_taken  = 1'b0;
        bus.in_pred_target = '0;
        bus.redirect_ready = 1'b0;
        bus.clr_stats      = 1'b0;

        @(negedge clk);
        doReset();

        // BEQ hit predicted not-taken -> redirect to 0x120
        applyStimulus(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2, -1);
        // BLT signed, correctly predicted taken
        applyStimulus(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b0, 1'b1, 32'h240, 1'b0, 0, -1);
        // BLTU same operands, predicted taken -> not taken, redirect pc+4
        applyStimulus(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 1'b0, 1'b1, 32'h240, 1'b0, 1, -1);
        // JALR to misaligned target 0x1002
        applyStimulus(32'h300, 32'h0, 32'h1003, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, -1);
        // jal and jalr both set behaves as jalr
        applyStimulus(32'h400, 32'h8, 32'h2000, 32'h0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h2008, 1'b0, 0, -1);
        // Illegal conditional op predicted taken
        applyStimulus(32'h500, 32'h10, 32'h1, 32'h1, 3'b011, 1'b0, 1'b0, 1'b1, 32'h510, 1'b0, 0, -1);
        // Address wrap-around
        applyStimulus(32'hFFFF_FFF0, 32'h20, 32'h3, 32'h3, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, -1);
        // Redirect back-pressure with reset pulsed in the middle
        applyStimulus(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5, 3);

        // Saturation: five correctly predicted not-taken branches
        for (int i = 0; i < 5; i++)
            applyStimulus(32'h600 + 32'(i * 4), 32'h40, 32'd7, 32'd7, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, -1);
        // Clear coinciding with an increment
        applyStimulus(32'h700, 32'h40, 32'd7, 32'd8, 3'b000, 1'b0, 1'b0, 1'b1, 32'h740, 1'b1, 1, -1);

        for (int n = 0; n < 150; n++) begin
            rPc  = $urandom & 32'hFFFF_FFFC;
            rImm = $urandom;
            if ($urandom_range(0, 3) != 0) rImm[1:0] = 2'b00;
            rRs1 = $urandom;
            if ($urandom_range(0, 3) == 0) rRs1 = 32'($urandom_range(0, 7)) - 32'd4;
            rRs2 = ($urandom_range(0, 2) == 0) ? rRs1 : $urandom;
            rOp  = 3'($urandom_range(0, 7));
            rJal  = ($urandom_range(0, 4) == 0);
            rJalr = ($urandom_range(0, 4) == 0);
            rPt   = 1'($urandom_range(0, 1));
            rTgt  = ($urandom_range(0, 1) == 1) ? modelTarget(rPc, rImm, rRs1, rJalr) : $urandom;
            rClr  = ($urandom_range(0, 5) == 0);
            rWait = int'($urandom_range(0, 3));
            applyStimulus(rPc, rImm, rRs1, rRs2, rOp, rJal, rJalr, rPt, rTgt, rClr, rWait, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Execute-stage controller that sequences the branch comparator for one branch or jump at a time and resolves its outcome.
- Computes the branch target and checks it against the fetch-stage prediction.
- On a mispredict or misaligned target, issues a pipeline flush and a PC redirect to fetch using a valid/ready handshake.
- Keeps saturating counters of resolved branches and mispredicts for performance monitoring.

Parameters:
- XLEN, 32, datapath and PC width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  branch or jump offered by decode.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_pc  in  XLEN  PC of the branch.
- in_imm  in  XLEN  sign-extended B/J/I immediate.
- in_rs1_data  in  XLEN  rs1 operand.
- in_rs2_data  in  XLEN  rs2 operand.
- in_br_op  in  3  funct3 compare code: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- in_is_jal  in  1  unconditional direct jump.
- in_is_jalr  in  1  unconditional register-indirect jump.
- in_pred_taken  in  1  fetch prediction: taken.
- in_pred_target  in  XLEN  fetch predicted target.
- res_valid  out  1  one-cycle result pulse.
- res_taken  out  1  resolved direction.
- res_link  out  XLEN  pc+4, used for the rd writeback of jal/jalr.
- flush  out  1  one-cycle pulse that kills younger instructions.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  corrected next PC.
- misalign_exc  out  1  one-cycle pulse: taken target with target[1]=1.
- illegal_op  out  1  one-cycle pulse: conditional branch with br_op 010 or 011.
- clr_stats  in  1  synchronous clear of both counters.
- br_cnt  out  CNT_W  count of resolved instructions.
- mispred_cnt  out  CNT_W  count of mispredicts.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; every output register is 0; in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- States: IDLE, RESOLVE, REDIRECT.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture all in_* fields into registers and go to RESOLVE.
- RESOLVE (exactly one cycle):
  - The registered rs1, rs2 and br_op drive the branch comparator instance.
  - taken = is_jal | is_jalr | cmp_taken. Comparisons are signed for LT/GE and unsigned for LTU/GEU.
  - target = is_jalr ? ((rs1+imm) & ~1) : (pc+imm). All arithmetic is mod 2^XLEN; wrap-around is silent.
  - next_pc = taken ? target : pc+4.
  - mispred = (taken != pred_taken) | (taken & (target != pred_target)).
  - Output pulses: res_valid=1, res_taken=taken, res_link=pc+4; br_cnt increments.
  - If is_jal and is_jalr are both set, treat the instruction as jalr.
  - Illegal op: illegal_op=1 and taken=0 (comparator default), only for conditional branches.
- Misaligned target (taken & target[1]):
  - misalign_exc=1 and flush=1; no redirect; mispred_cnt does not increment.
  - Go to IDLE; the trap unit owns the redirect.
- Mispredict (otherwise, if mispred):
  - flush=1 this cycle and mispred_cnt increments.
  - redirect_pc is loaded with next_pc; go to REDIRECT.
- Otherwise go to IDLE.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable.
  - When redirect_ready is high, drop redirect_valid next cycle and go to IDLE.
  - Waiting is unbounded; in_ready stays 0 throughout.
- Throughput: one instruction per 2 cycles when there is no mispredict, plus the redirect wait when there is one.
- Latency: accept edge to res_valid is 1 cycle.
- Counters: saturate at all-ones; no wrap.
  - clr_stats wins over a simultaneous increment; both counters read 0 the following cycle.
- Reset asserted mid-operation:
  - Any pending redirect is dropped and no pulse is emitted.
  - Counters return to 0.

Decomposition:
- Shared package holds:
  - The funct3 compare encodings (BR_EQ..BR_GEU).
  - The state enum typedef.
  - The link-offset constant 4.
- Sub-module: the existing branch_comp comparator is instantiated once and fed from the capture registers.
- The FSM, target adder and counters stay in this module.

Test Plan:
- BEQ hit, predicted not-taken: pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=0 -> res_valid with res_taken=1 at T+1; flush=1; redirect_pc=0x120 held until redirect_ready; mispred_cnt=1.
- BLT signed, correct prediction: rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pred_target=pc+imm -> taken, no flush, no redirect, br_cnt=1, in_ready back at T+2.
- BLTU, same operands, pred_taken=1 -> not taken; redirect_pc=pc+4; flush=1.
- JALR, rs1=0x1003, imm=0 -> target 0x1002, misalign_exc=1, flush=1, no redirect_valid; res_link=pc+4.
- Back-pressure: hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable, in_ready=0; rst_n pulsed low in cycle 3 -> all outputs 0 immediately, IDLE after release.
- Counters: CNT_W=2, run 5 branches -> br_cnt saturates at 3; clr_stats in the same cycle as an increment -> 0.
